led_pattern_gen: RTL and testbench

//  Parametrised multi-channel LED driver; successor to the single free-running blink counter.
//  NUM_CH independent channels; each runs OFF / ON / BLINK / PWM with its own period and duty.
//  A shared prescaler divides clk before the channel counters.

---
 rtl/led_pattern_gen.sv | 155 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler, NUM_CH independent
// OFF/ON/BLINK/PWM channels, reconfigured through a valid/ready write port.

// One LED channel: counter, wrap pulse and mode-dependent LED register.
module led_pattern_chan #(
    parameter int          CNT_W      = 27,
    parameter int unsigned RST_PERIOD = 2**26-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_wr,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_led,
    output logic             o_wrap
);
    localparam logic [1:0]       M_OFF   = 2'd0;
    localparam logic [1:0]       M_ON    = 2'd1;
    localparam logic [1:0]       M_BLINK = 2'd2;
    localparam logic [1:0]       M_PWM   = 2'd3;
    localparam logic [CNT_W-1:0] RST_P   = CNT_W'(RST_PERIOD);

    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic             r_wrap;
    logic             w_at_end;
    logic [CNT_W-1:0] w_cnt_next;

    // cnt never exceeds period, so the increment cannot overflow
    assign w_at_end   = (r_cnt == r_period);
    assign w_cnt_next = w_at_end ? '0 : r_cnt + 1'b1;

    // A config write to this channel takes priority over a tick on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode   <= M_BLINK;
            r_period <= RST_P;
            r_duty   <= RST_P >> 1;
            r_cnt    <= '0;
            r_led    <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (i_wr) begin
            r_mode   <= i_mode;
            r_period <= i_period;
            r_duty   <= i_duty;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
            case (i_mode)
                M_ON:    r_led <= 1'b1;
                M_PWM:   r_led <= (i_duty != '0);
                default: r_led <= 1'b0;
            endcase
        end else if (i_tick) begin
            r_cnt  <= w_cnt_next;
            r_wrap <= w_at_end;
            case (r_mode)
                M_OFF:   r_led <= 1'b0;
                M_ON:    r_led <= 1'b1;
                M_BLINK: r_led <= r_led ^ w_at_end;
                M_PWM:   r_led <= (w_cnt_next < r_duty);
                default: r_led <= 1'b0;
            endcase
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_led  = r_led;
    assign o_wrap = r_wrap;
endmodule

// Top: prescaler, config port and the channel array.
module led_pattern_gen #(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 27,
    parameter int          PRESCALE   = 1,
    parameter int unsigned RST_PERIOD = 2**26-1,
    parameter int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] wrap,
    output logic [NUM_CH-1:0] led
);
    localparam int              PRE_W  = $clog2(PRESCALE) + 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [CH_W:0]   NCH    = (CH_W+1)'(NUM_CH);

    logic [PRE_W-1:0]  r_pre;
    logic              r_ready;
    logic              r_err;
    logic              w_tick;
    logic              w_acc;
    logic              w_bad_ch;
    logic [NUM_CH-1:0] w_hit;

    assign w_tick   = (r_pre == PRE_MAX);
    assign w_acc    = cfg_valid & r_ready;
    assign w_bad_ch = ({1'b0, cfg_ch} >= NCH);

    // Prescaler: counts 0..PRESCALE-1, tick on the terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_pre <= '0;
        else if (w_tick) r_pre <= '0;
        else             r_pre <= r_pre + 1'b1;
    end

    // Handshake: ready drops for one cycle after each accept; bad channel flags an error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_ready <= ~w_acc;
            r_err   <= w_acc & w_bad_ch;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_hit[gi] = w_acc & (cfg_ch == CH_W'(gi));

            led_pattern_chan #(
                .CNT_W      (CNT_W),
                .RST_PERIOD (RST_PERIOD)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_tick   (w_tick),
                .i_wr     (w_hit[gi]),
                .i_mode   (cfg_mode),
                .i_period (cfg_period),
                .i_duty   (cfg_duty),
                .o_led    (led[gi]),
                .o_wrap   (wrap[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a PRESCALE=2 instance (a) and a
// PRESCALE=1 instance (b), both NUM_CH=3, CNT_W=8, RST_PERIOD=3.
module tb_led_pattern_gen;
    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic       va = 1'b0, vb = 1'b0;
    logic [1:0] cha = '0, chb = '0, ma = '0, mb = '0;
    logic [7:0] pa = '0, pb = '0, da = '0, db = '0;
    logic       rdy_a, rdy_b, err_a, err_b;
    logic [2:0] wrap_a, wrap_b, led_a, led_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.NUM_CH(3), .CNT_W(8), .PRESCALE(2), .RST_PERIOD(3)) dut_a (
        .clk(clk), .rst(rst_a), .cfg_valid(va), .cfg_ready(rdy_a), .cfg_ch(cha),
        .cfg_mode(ma), .cfg_period(pa), .cfg_duty(da), .cfg_err(err_a),
        .wrap(wrap_a), .led(led_a));

    led_pattern_gen #(.NUM_CH(3), .CNT_W(8), .PRESCALE(1), .RST_PERIOD(3)) dut_b (
        .clk(clk), .rst(rst_b), .cfg_valid(vb), .cfg_ready(rdy_b), .cfg_ch(chb),
        .cfg_mode(mb), .cfg_period(pb), .cfg_duty(db), .cfg_err(err_b),
        .wrap(wrap_b), .led(led_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ---------------- instance a, PRESCALE=2 ----------------
        step(2);
        chk("rst_led", led_a, 3'b000);
        chk("rst_wrap", wrap_a, 3'b000);
        chk("rst_err", err_a, 0);
        chk("rst_ready", rdy_a, 1);
        rst_a = 1'b1;                      // next edge is edge 1
        step(7);
        chk("e7_led", led_a, 3'b000);
        chk("e7_wrap", wrap_a, 3'b000);
        step(1);                           // edge 8: first wrap
        chk("e8_led", led_a, 3'b111);
        chk("e8_wrap", wrap_a, 3'b111);
        step(1);
        chk("e9_wrap", wrap_a, 3'b000);
        chk("e9_led", led_a, 3'b111);
        step(7);                           // edge 16
        chk("e16_led", led_a, 3'b000);
        chk("e16_wrap", wrap_a, 3'b111);

        // write ch1 ON
        va = 1; cha = 2'd1; ma = 2'd1; pa = 8'd3; da = 8'd0;
        step(1);                           // edge 17 accept
        chk("on_led", led_a, 3'b010);
        chk("on_ready_lo", rdy_a, 0);
        va = 0;
        step(1);                           // edge 18
        chk("on_ready_hi", rdy_a, 1);
        step(6);                           // edge 24
        chk("e24_led", led_a, 3'b111);
        chk("e24_wrap", wrap_a, 3'b111);

        // bad channel, then back-to-back valid
        va = 1; cha = 2'd3; ma = 2'd0;
        step(1);                           // edge 25
        chk("err_pulse", err_a, 1);
        chk("err_led", led_a, 3'b111);
        chk("err_ready", rdy_a, 0);
        cha = 2'd0; ma = 2'd0;             // still valid, ignored this edge
        step(1);                           // edge 26
        chk("err_clear", err_a, 0);
        chk("b2b_ignored", led_a, 3'b111);
        chk("b2b_ready", rdy_a, 1);
        step(1);                           // edge 27 second accept
        chk("b2b_led", led_a, 3'b110);
        chk("b2b_err", err_a, 0);
        va = 0;

        // write ch2 on its wrap edge (edge 32)
        step(4);
        va = 1; cha = 2'd2; ma = 2'd2; pa = 8'd3; da = 8'd1;
        step(1);                           // edge 32
        chk("wwin_wrap", wrap_a, 3'b010);
        chk("wwin_led", led_a, 3'b010);
        va = 0;
        step(6);                           // edge 38
        chk("e38_wrap", wrap_a, 3'b000);
        step(2);                           // edge 40
        chk("e40_wrap", wrap_a, 3'b110);
        chk("e40_led", led_a, 3'b110);

        // ch0 PWM, then reset mid-operation with a pending write
        va = 1; cha = 2'd0; ma = 2'd3; pa = 8'd3; da = 8'd2;
        step(1);                           // edge 41
        chk("pwm_led", led_a, 3'b111);
        cha = 2'd1; ma = 2'd0;             // pending write, never accepted
        #2 rst_a = 1'b0;
        #1;
        chk("arst_led", led_a, 3'b000);
        chk("arst_wrap", wrap_a, 3'b000);
        chk("arst_err", err_a, 0);
        chk("arst_ready", rdy_a, 1);
        step(2);
        va = 0;
        rst_a = 1'b1;
        step(7);
        chk("r_e7_led", led_a, 3'b000);
        step(1);
        chk("r_e8_led", led_a, 3'b111);
        chk("r_e8_wrap", wrap_a, 3'b111);

        // ---------------- instance b, PRESCALE=1 ----------------
        rst_b = 1'b1;
        vb = 1; chb = 2'd2; mb = 2'd3; pb = 8'd9; db = 8'd3;
        step(1);                           // edge 1: accept, ch2 PWM
        chk("b_pwm_e1_led", led_b[2], 1);
        chk("b_pwm_e1_wrap", wrap_b[2], 0);
        vb = 0;
        for (int e = 2; e <= 21; e++) begin
            step(1);
            chk("b_pwm_led", led_b[2], (((e - 1) % 10) < 3) ? 1 : 0);
            chk("b_pwm_wrap", wrap_b[2], (((e - 1) % 10) == 0) ? 1 : 0);
        end
        vb = 1; chb = 2'd2; mb = 2'd3; pb = 8'd9; db = 8'd0;
        step(1);                           // edge 22
        vb = 0;
        step(1);
        vb = 1; chb = 2'd1; mb = 2'd3; pb = 8'd9; db = 8'd200;
        step(1);                           // edge 24
        vb = 0;
        step(1);
        vb = 1; chb = 2'd0; mb = 2'd2; pb = 8'd0; db = 8'd0;
        step(1);                           // edge 26
        chk("b_p0_init", led_b[0], 0);
        vb = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("b_p0_led", led_b[0], k[0]);
            chk("b_p0_wrap", wrap_b[0], 1);
            chk("b_d200_led", led_b[1], 1);
            chk("b_d0_led", led_b[2], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
